// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner: rotating active-low row drive, per-key debounce,
// press/release events queued in a 4-deep FIFO behind a small register map.

module keypad_debounce #(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sample,
    input  logic raw,
    output logic state,
    output logic flip
);
    logic [3:0] cnt;

    // flip fires on the sample that would bring the counter up to DEBOUNCE_SCANS
    assign flip = sample && (raw != state) && (cnt == 4'(DEBOUNCE_SCANS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= 1'b0;
            cnt   <= '0;
        end else if (sample) begin
            if (raw == state || flip) cnt <= '0;
            else                      cnt <= cnt + 4'd1;
            if (flip) state <= raw;
        end
    end
endmodule

module keypad_scanner #(
    parameter int SCAN_DIV       = 8,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        write_enable,
    input  logic [31:0] write_data,
    output logic [31:0] read_result,
    output logic        irq,
    output logic [3:0]  key_row,
    input  logic [3:0]  key_col
);
    localparam int NUM_KEYS   = 16;
    localparam int COLS       = 4;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic       press;
        logic [3:0] idx;
    } key_event_t;

    logic [15:0] ctr;
    logic [1:0]  row_idx;
    logic        scan_tick;

    assign scan_tick = (ctr == '0);
    assign key_row   = ~(4'b0001 << row_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr     <= 16'(SCAN_DIV - 1);
            row_idx <= '0;
        end else if (scan_tick) begin
            ctr     <= 16'(SCAN_DIV - 1);
            row_idx <= row_idx + 2'd1;
        end else begin
            ctr <= ctr - 16'd1;
        end
    end

    logic [NUM_KEYS-1:0] state;
    logic [NUM_KEYS-1:0] flip;

    generate
        for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
            keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_db (
                .clk    (clk),
                .rst    (rst),
                .sample (scan_tick && (row_idx == 2'(k / COLS))),
                .raw    (~key_col[k % COLS]),
                .state  (state[k]),
                .flip   (flip[k])
            );
        end
    endgenerate

    logic [3:0] pending;
    logic [1:0] pend_row;
    logic [1:0] push_col;
    logic       push_vld;
    key_event_t push_evt;

    always_comb begin
        push_col = '0;
        for (int c = COLS - 1; c >= 0; c--)
            if (pending[c]) push_col = 2'(c);
    end

    assign push_vld       = |pending;
    assign push_evt.idx   = {pend_row, push_col};
    assign push_evt.press = state[{pend_row, push_col}];

    // flips only occur on a sample edge, so OR-ing them in needs no extra gating
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            pend_row <= '0;
        end else begin
            pending <= (pending & ~(push_vld ? (4'b0001 << push_col) : 4'b0000))
                     | flip[{row_idx, 2'b00} +: 4];
            if (scan_tick) pend_row <= row_idx;
        end
    end

    key_event_t [FIFO_DEPTH-1:0] fifo_mem;
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] count;
    logic       nonempty, full, pop, push;
    logic       overflow, irq_en;
    key_event_t head;

    assign nonempty = (count != 3'd0);
    assign full     = (count == 3'(FIFO_DEPTH));
    assign pop      = write_enable && (addr == 2'd1) && nonempty;
    assign push     = push_vld && (!full || pop);
    assign head     = nonempty ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= push_evt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            irq_en   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            count <= count + 3'(push) - 3'(pop);
            // a dropped event in the same cycle as a clear keeps the flag set
            if (push_vld && !push)
                overflow <= 1'b1;
            else if (write_enable && addr == 2'd1 && write_data[16])
                overflow <= 1'b0;
            if (write_enable && addr == 2'd2) irq_en <= write_data[0];
        end
    end

    always_comb begin
        read_result = '0;
        case (addr)
            2'd0:    read_result = {16'b0, state};
            2'd1:    read_result = {nonempty, 14'b0, overflow, 5'b0, count, 3'b0, head};
            2'd2:    read_result = {31'b0, irq_en};
            default: read_result = '0;
        endcase
    end

    assign irq = irq_en & nonempty;

    logic unused_wdata;
    assign unused_wdata = ^{write_data[31:17], write_data[15:1]};
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=8, DEBOUNCE_SCANS=2) with a
// behavioural key matrix driving key_col from the pressed-key vector.

module tb_keypad_scanner;
    logic        clk;
    logic        rst;
    logic [1:0]  addr;
    logic        write_enable;
    logic [31:0] write_data;
    logic [31:0] read_result;
    logic        irq;
    logic [3:0]  key_row;
    logic [3:0]  key_col;
    logic [15:0] pressed;

    int n_checks = 0;
    int n_fail   = 0;

    keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE_SCANS(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .write_enable (write_enable),
        .write_data   (write_data),
        .read_result  (read_result),
        .irq          (irq),
        .key_row      (key_row),
        .key_col      (key_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // closed switch pulls its column low while its row is driven
    always_comb begin
        key_col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!key_row[r] && pressed[r*4+c]) key_col[c] = 1'b0;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, read_result, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr         = a;
        write_data   = d;
        write_enable = 1'b1;
        step(1);
        write_enable = 1'b0;
        write_data   = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; addr = '0; write_enable = 1'b0; write_data = '0; pressed = '0;

        // idle scan rotation
        do_reset();
        chk("rst_row", {28'b0, key_row}, 32'hE);
        chk_reg("rst_keys", 2'd0, 32'h0);
        chk_reg("rst_event", 2'd1, 32'h0);
        chk_reg("rst_ctrl", 2'd2, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        step(7);
        chk("row_e7", {28'b0, key_row}, 32'hE);
        step(1);
        chk("row_e8", {28'b0, key_row}, 32'hD);
        step(8);
        chk("row_e16", {28'b0, key_row}, 32'hB);
        step(8);
        chk("row_e24", {28'b0, key_row}, 32'h7);
        step(8);
        chk("row_e32", {28'b0, key_row}, 32'hE);

        // key 6 held from reset release
        pressed = 16'h0040;
        do_reset();
        step(47);
        chk_reg("k6_e47_keys", 2'd0, 32'h0);
        step(1);
        chk_reg("k6_e48_keys", 2'd0, 32'h40);
        chk_reg("k6_e48_event", 2'd1, 32'h0);
        step(1);
        chk_reg("k6_e49_event", 2'd1, 32'h80000116);
        chk("k6_irq_off", {31'b0, irq}, 32'h0);
        wr(2'd2, 32'h1);
        chk("k6_irq_on", {31'b0, irq}, 32'h1);
        chk_reg("k6_ctrl", 2'd2, 32'h1);
        chk_reg("k6_addr3", 2'd3, 32'h0);
        wr(2'd1, 32'h0);
        chk_reg("k6_pop", 2'd1, 32'h0);
        chk("k6_irq_empty", {31'b0, irq}, 32'h0);

        // bounce: single-sample presses never flip the key
        pressed = 16'h0040;
        do_reset();
        step(16);
        pressed = 16'h0000;
        step(40);
        chk_reg("bounce_keys", 2'd0, 32'h0);
        chk_reg("bounce_event", 2'd1, 32'h0);
        pressed = 16'h0040;
        step(24);
        pressed = 16'h0000;
        step(40);
        chk_reg("bounce2_keys", 2'd0, 32'h0);
        chk_reg("bounce2_event", 2'd1, 32'h0);

        // row burst: keys 4..7
        pressed = 16'h00F0;
        do_reset();
        step(48);
        chk_reg("burst_e48_keys", 2'd0, 32'hF0);
        chk_reg("burst_e48_event", 2'd1, 32'h0);
        step(1);
        chk_reg("burst_e49", 2'd1, 32'h80000114);
        step(1);
        chk_reg("burst_e50", 2'd1, 32'h80000214);
        step(2);
        chk_reg("burst_e52", 2'd1, 32'h80000414);
        wr(2'd1, 32'h0);
        chk_reg("burst_pop1", 2'd1, 32'h80000315);
        wr(2'd1, 32'h0);
        chk_reg("burst_pop2", 2'd1, 32'h80000216);
        wr(2'd1, 32'h0);
        chk_reg("burst_pop3", 2'd1, 32'h80000117);
        wr(2'd1, 32'h0);
        chk_reg("burst_pop4", 2'd1, 32'h0);

        // overflow: release 4..7 fills the FIFO, key 8 press is dropped (edge 56 now)
        pressed = 16'h0100;
        step(60);
        chk_reg("ovf_full", 2'd1, 32'h80000404);
        step(5);
        chk_reg("ovf_set", 2'd1, 32'h80010404);
        wr(2'd1, 32'h00010000);
        chk_reg("ovf_clear", 2'd1, 32'h80000305);

        // key 5 press fills FIFO at 177; key 8 release pushes at 185 alongside a pop
        pressed = 16'h0020;
        step(54);
        chk_reg("pp_e176_keys", 2'd0, 32'h0120);
        chk_reg("pp_e176_event", 2'd1, 32'h80000305);
        step(1);
        chk_reg("pp_e177", 2'd1, 32'h80000405);
        step(7);
        chk_reg("pp_e184_keys", 2'd0, 32'h0020);
        chk_reg("pp_e184_event", 2'd1, 32'h80000405);
        wr(2'd1, 32'h0);
        chk_reg("pp_pushpop", 2'd1, 32'h80000406);
        wr(2'd1, 32'h0);
        chk_reg("pp_pop_a", 2'd1, 32'h80000307);
        wr(2'd1, 32'h0);
        chk_reg("pp_pop_b", 2'd1, 32'h80000215);

        // reset with two events queued and key 5 held
        wr(2'd2, 32'h1);
        chk("pre_rst_irq", {31'b0, irq}, 32'h1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk_reg("mid_rst_event", 2'd1, 32'h0);
        chk_reg("mid_rst_keys", 2'd0, 32'h0);
        chk_reg("mid_rst_ctrl", 2'd2, 32'h0);
        chk("mid_rst_row", {28'b0, key_row}, 32'hE);
        chk("mid_rst_irq", {31'b0, irq}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Memory-mapped input peripheral for a 4x4 key matrix; the input-side counterpart of the multiplexed display driver on the same device bus.
- Drives one matrix row at a time using the same rotating one-hot phase scheme as the display digit select, and samples the columns.
- Debounces each key and queues press/release events in a 4-deep FIFO.
- CPU reads keys and events over the standard addr/write_enable/write_data/read_result/irq device interface.

Parameters:
- SCAN_DIV, 8, clock cycles per row dwell; legal range 8..2^16.
- DEBOUNCE_SCANS, 4, consecutive differing samples of one key required to flip its state; legal range 1..15.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- addr  input  2  register select
- write_enable  input  1  register write strobe, one cycle
- write_data  input  32  write data
- read_result  output  32  combinational read data for addr
- irq  output  1  interrupt request, level
- key_row  output  4  row drive, active-low one-hot
- key_col  input  4  column sense, active-low (0 = pressed), pulled up externally

Interface decision: one clock, clk; reset is rst, synchronous and active-high.

Behaviour:
- Reset state:
  - key_row=4'b1110 (row 0 driven).
  - Divider ctr=SCAN_DIV-1.
  - All key states 0 (released); all debounce counters 0; pending mask 0.
  - FIFO empty; overflow=0; irq_en=0.
  - irq=0. read_result follows addr from register values.
- Scan timing:
  - While ctr>0: ctr decrements.
  - At ctr==0, on the edge: sample key_col for the current row, reload ctr=SCAN_DIV-1, rotate key_row 1110→1101→1011→0111→1110.
  - First sample after reset is on the SCAN_DIV-th edge with rst=0. One full matrix pass takes 4*SCAN_DIV cycles.
  - Scanning never stalls on register writes.
- Key index = row*4+col. Raw pressed = ~key_col[col] at the sample edge.
- Debounce, per key, at that key's sample only:
  - raw==state: counter<=0.
  - Otherwise counter increments; when it reaches DEBOUNCE_SCANS, state<=raw, counter<=0, and the key's column bit is set in the 4-bit pending mask.
- Event generation:
  - On each cycle after a sample, the lowest set pending bit is pushed as an event {press=new state, index} and cleared.
  - At most one push per cycle; a full row drains within 4 cycles, before the next sample.
  - Pending bits are tagged with the row they were sampled on.
- FIFO:
  - 4 entries, 5-bit events.
  - Push when full: event dropped, overflow<=1 (sticky).
  - Pop = write_enable with addr==1. Pop when empty is ignored.
  - Simultaneous push and pop: both occur; count unchanged. A push into a full FIFO with a same-cycle pop succeeds.
- Registers:
  - addr 0 KEYS: read {16'b0, state[15:0]}, bit n = key n pressed. Writes ignored.
  - addr 1 EVENT: read bit31=nonempty, bit16=overflow, bits10:8=count (0..4), bit4=head press flag, bits3:0=head index; head fields 0 when empty, other bits 0. Write: pop; if write_data[16]=1, also clear overflow (a same-cycle overflow set wins).
  - addr 2 CTRL: bit0=irq_en, read/write, other bits read 0.
  - addr 3: reads 0, writes ignored.
- irq = irq_en & nonempty, combinational from registers.
- Reset mid-scan or mid-drain discards pending events and returns all state to reset values on that edge.

Test Plan:
- Bench parameters SCAN_DIV=8, DEBOUNCE_SCANS=2.
- Idle after reset: key_col=4'hF. key_row follows the rotation every 8 cycles starting at edge 8; addr0 reads 0x0; addr1 reads 0x00000000; irq=0.
- Press key 6 (row1, col2), held from reset release:
  - State flips at edge 48 (samples at edges 16 and 48).
  - addr0 reads 0x00000040 after edge 48.
  - addr1 reads 0x80000116 after edge 49.
  - With CTRL=1, irq=1.
- Bounce rejection: key 6 low for only one row-1 sample, then high -> no state change, FIFO stays empty.
- Row burst: keys 4..7 pressed together -> four events pushed on consecutive cycles in index order 4,5,6,7; count reads 4; popping four times yields 0x14,0x15,0x16,0x17 in bits4:0, then addr1 reads 0.
- Overflow and edge cases:
  - FIFO full plus one more release -> overflow bit16=1, count stays 4.
  - Writing 0x00010000 to addr1 pops one entry and clears overflow.
  - A pop coinciding with a push keeps count unchanged.
- Reset with 2 events queued and key held -> next cycle addr1=0, addr0=0, key_row=4'b1110, irq=0.
